// File: rtl/time_set_ctrl_pkg.sv
// time_set_ctrl_pkg: field select codes and RUN/SET state encoding,
// shared by the set controller and the time counter.
package time_set_ctrl_pkg;
   localparam logic [2:0] SEL_SEC   = 3'b000;
   localparam logic [2:0] SEL_MIN   = 3'b001;
   localparam logic [2:0] SEL_HOUR  = 3'b010;
   localparam logic [2:0] SEL_DAY   = 3'b011;
   localparam logic [2:0] SEL_MONTH = 3'b100;
   localparam logic [2:0] SEL_YEAR  = 3'b101;
   localparam logic [2:0] SEL_NONE  = 3'b111;
   typedef enum logic {RUN = 1'b0, SET = 1'b1} clk_state_t;
endpackage

// File: rtl/time_set_ctrl_btn_sync_edge.sv
// btn_sync_edge: 2-flop synchronizer, previous-value stage and press detect.
// A button held through reset stays ignored until it is seen released.
module btn_sync_edge (
   input  logic clk_1Hz,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_hold,
   output logic o_press
);
   logic       r_s1, r_s2, r_prev, r_armed;
   logic [1:0] r_vld;
   always_ff @(posedge clk_1Hz or negedge rst_n)
      if (!rst_n) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_prev  <= 1'b0;
         r_vld   <= 2'b00;
         r_armed <= 1'b0;
      end else begin
         r_s1    <= i_btn;
         r_s2    <= r_s1;
         r_prev  <= r_s2;
         r_vld   <= {r_vld[0], 1'b1};
         // arm only once the synchronizer carries a real post-reset low
         r_armed <= r_armed | (r_vld[1] & ~r_s2);
      end
   assign o_hold  = r_s2 & r_armed;
   assign o_press = o_hold & ~r_prev;
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: RUN/SET mode controller for clock setting with field select,
// auto-repeat up/down pulses, blink strobe and idle timeout.
module time_set_ctrl
   import time_set_ctrl_pkg::*;
#(
   parameter logic [2:0] SELECT_SEC   = SEL_SEC,
   parameter logic [2:0] SELECT_MIN   = SEL_MIN,
   parameter logic [2:0] SELECT_HOUR  = SEL_HOUR,
   parameter logic [2:0] SELECT_DAY   = SEL_DAY,
   parameter logic [2:0] SELECT_MONTH = SEL_MONTH,
   parameter logic [2:0] SELECT_YEAR  = SEL_YEAR,
   parameter logic [2:0] SELECT_NONE  = SEL_NONE,
   parameter int         TIMEOUT      = 30,
   parameter int         REPEAT_DELAY = 2
)(
   input  logic       clk_1Hz,
   input  logic       rst_n,
   input  logic       btn_mode,
   input  logic       btn_next,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic       en_1,
   output logic [2:0] select_item,
   output logic       up,
   output logic       down,
   output logic       blink
);
   localparam int IW = $clog2(TIMEOUT);
   localparam int RW = $clog2(REPEAT_DELAY + 2);
   localparam logic [RW-1:0] RD = RW'(REPEAT_DELAY);

   logic [3:0]    w_raw, w_hold, w_press;
   clk_state_t    r_state;
   logic          r_en_1, r_up, r_down, r_blink;
   logic [2:0]    r_sel, w_sel_nxt;
   logic [IW-1:0] r_idle;
   logic [RW-1:0] r_rep_up, r_rep_dn, w_rep_up_nxt, w_rep_dn_nxt;
   logic          w_both, w_up, w_dn, w_exit;

   assign w_raw = {btn_down, btn_up, btn_next, btn_mode};
   for (genvar i = 0; i < 4; i++) begin : g_btn
      btn_sync_edge u_btn (
         .clk_1Hz (clk_1Hz),
         .rst_n   (rst_n),
         .i_btn   (w_raw[i]),
         .o_hold  (w_hold[i]),
         .o_press (w_press[i])
      );
   end

   // a press fires at once; a continued hold fires every cycle once the delay is used up
   assign w_both       = w_hold[2] & w_hold[3];
   assign w_up         = ~w_both & (w_press[2] | (w_hold[2] & (r_rep_up == RD)));
   assign w_dn         = ~w_both & (w_press[3] | (w_hold[3] & (r_rep_dn == RD)));
   assign w_rep_up_nxt = (w_both | ~w_hold[2] | w_press[2]) ? '0 :
                         (r_rep_up == RD) ? r_rep_up : r_rep_up + 1'b1;
   assign w_rep_dn_nxt = (w_both | ~w_hold[3] | w_press[3]) ? '0 :
                         (r_rep_dn == RD) ? r_rep_dn : r_rep_dn + 1'b1;
   assign w_exit       = w_press[0] | (~|w_hold & (r_idle == IW'(TIMEOUT - 1)));
   assign w_sel_nxt    = (r_sel == SELECT_SEC)   ? SELECT_MIN   :
                         (r_sel == SELECT_MIN)   ? SELECT_HOUR  :
                         (r_sel == SELECT_HOUR)  ? SELECT_DAY   :
                         (r_sel == SELECT_DAY)   ? SELECT_MONTH :
                         (r_sel == SELECT_MONTH) ? SELECT_YEAR  : SELECT_SEC;

   always_ff @(posedge clk_1Hz or negedge rst_n)
      if (!rst_n) begin
         r_state  <= RUN;
         r_en_1   <= 1'b1;
         r_sel    <= SELECT_NONE;
         r_up     <= 1'b0;
         r_down   <= 1'b0;
         r_blink  <= 1'b0;
         r_idle   <= '0;
         r_rep_up <= '0;
         r_rep_dn <= '0;
      end else if (r_state == RUN || w_exit) begin
         r_up     <= 1'b0;
         r_down   <= 1'b0;
         r_idle   <= '0;
         r_rep_up <= '0;
         r_rep_dn <= '0;
         if (r_state == RUN && w_press[0]) begin
            r_state <= SET;
            r_en_1  <= 1'b0;
            r_sel   <= SELECT_SEC;
            r_blink <= 1'b1;
         end else begin
            r_state <= RUN;
            r_en_1  <= 1'b1;
            r_sel   <= SELECT_NONE;
            r_blink <= 1'b0;
         end
      end else begin
         r_sel    <= w_press[1] ? w_sel_nxt : r_sel;
         r_up     <= w_up;
         r_down   <= w_dn;
         r_rep_up <= w_rep_up_nxt;
         r_rep_dn <= w_rep_dn_nxt;
         r_idle   <= |w_hold ? '0 : (&r_idle ? r_idle : r_idle + 1'b1);
         r_blink  <= ~r_blink;
      end

   assign en_1        = r_en_1;
   assign select_item = r_sel;
   assign up          = r_up;
   assign down        = r_down;
   assign blink       = r_blink;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed stimulus for time_set_ctrl, checked every cycle
// against a behavioural model plus literal expectations at key points.
module tb_time_set_ctrl;
   localparam int TIMEOUT      = 30;
   localparam int REPEAT_DELAY = 2;

   logic       clk_1Hz = 1'b0;
   logic       rst_n   = 1'b1;
   logic [3:0] btn     = 4'b0000;
   logic       en_1, up, down, blink;
   logic [2:0] select_item;
   int         total = 0;
   int         bad   = 0;

   time_set_ctrl #(.TIMEOUT(TIMEOUT), .REPEAT_DELAY(REPEAT_DELAY)) dut (
      .clk_1Hz     (clk_1Hz),
      .rst_n       (rst_n),
      .btn_mode    (btn[0]),
      .btn_next    (btn[1]),
      .btn_up      (btn[2]),
      .btn_down    (btn[3]),
      .en_1        (en_1),
      .select_item (select_item),
      .up          (up),
      .down        (down),
      .blink       (blink)
   );

   always #5 clk_1Hz = ~clk_1Hz;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_1Hz);
   endtask

   task automatic pulse(input int b);
      btn[b] = 1'b1;
      tick(1);
      btn[b] = 1'b0;
   endtask

   // Model: buttons seen two edges late, ignored until seen released after reset;
   // hold length counts cycles since the last press (or up+down overlap).
   logic [3:0] m_h1 = '0, m_h2 = '0, m_last = '0, m_arm = '0, ms, mp, mhd;
   int         m_edges = 0, m_sel = 0, m_idle = 0, m_nu = 0, m_nd = 0;
   bit         m_run = 1, m_up = 0, m_dn = 0, m_blink = 0, m_both;

   always @(posedge clk_1Hz or negedge rst_n) begin
      if (!rst_n) begin
         m_h1 = '0; m_h2 = '0; m_last = '0; m_arm = '0; m_edges = 0;
         m_run = 1; m_sel = 0; m_up = 0; m_dn = 0; m_blink = 0;
         m_idle = 0; m_nu = 0; m_nd = 0;
      end else begin
         m_edges++;
         ms  = m_h2;
         mp  = ms & ~m_last & m_arm;
         mhd = ms & m_arm;
         if (m_edges >= 3) m_arm = m_arm | ~ms;
         m_last = ms;
         m_h2   = m_h1;
         m_h1   = btn;
         if (m_run) begin
            m_up = 0; m_dn = 0;
            if (mp[0]) begin
               m_run = 0; m_sel = 0; m_blink = 1; m_idle = 0; m_nu = 0; m_nd = 0;
            end
         end else if (mp[0] || (m_idle == TIMEOUT - 1 && mhd == 0)) begin
            m_run = 1; m_up = 0; m_dn = 0; m_blink = 0;
         end else begin
            if (mp[1]) m_sel = (m_sel + 1) % 6;
            m_both  = mhd[2] && mhd[3];
            m_nu    = (!mhd[2] || m_both || mp[2]) ? 0 : m_nu + 1;
            m_nd    = (!mhd[3] || m_both || mp[3]) ? 0 : m_nd + 1;
            m_up    = !m_both && (mp[2] || (mhd[2] && m_nu > REPEAT_DELAY));
            m_dn    = !m_both && (mp[3] || (mhd[3] && m_nd > REPEAT_DELAY));
            m_idle  = (mhd != 0) ? 0 : m_idle + 1;
            m_blink = !m_blink;
         end
      end
   end

   function automatic logic [6:0] m_vec();
      return {m_run, m_run ? 3'b111 : 3'(m_sel), m_up, m_dn, m_blink};
   endfunction

   always @(negedge clk_1Hz) begin
      chk("cycle", {en_1, select_item, up, down, blink}, m_vec());
      if (up && down) chk("up_down_exclusive", {up, down}, 2'b00);
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] pat;
      int         exp_sel [8];
      int         n;
      pat     = 7'b1001110;
      exp_sel = '{0, 1, 2, 3, 4, 5, 0, 1};
      #1 rst_n = 1'b0;
      #1 chk("reset_now", {en_1, select_item, up, down, blink}, 7'b1111000);
      tick(2);
      rst_n = 1'b1;
      // idle after reset
      for (int i = 0; i < 40; i++) begin
         tick(1);
         chk("run_idle", {en_1, select_item, up, down}, 6'b111100);
      end
      // enter SET and walk the fields
      pulse(0);
      tick(2);
      chk("set_entry", {en_1, select_item, blink}, 5'b0_000_1);
      for (int i = 1; i < 8; i++) begin
         pulse(1);
         tick(2);
         chk("sel_walk", select_item, exp_sel[i]);
         chk("sel_walk_en", en_1, 0);
      end
      // hold up for six cycles: press, delay, then repeat
      btn[2] = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick(1);
         if (i == 5) btn[2] = 1'b0;
         if (i >= 2) chk("up_pattern", up, pat[8 - i]);
      end
      // up+down together keeps outputs quiet but still counts as activity
      tick(20);
      btn[3:2] = 2'b11;
      for (int i = 0; i < 7; i++) begin
         tick(1);
         chk("both_quiet", {up, down}, 2'b00);
      end
      btn[3:2] = 2'b00;
      tick(20);
      chk("idle_cleared", en_1, 0);
      n = 0;
      while (!en_1 && n < 40) begin
         tick(1);
         n++;
      end
      chk("timeout_after_both", en_1, 1);
      // idle timeout measured from entry
      pulse(0);
      tick(2);
      chk("timeout_entry", en_1, 0);
      n = 0;
      while (!en_1 && n < 60) begin
         tick(1);
         n++;
      end
      chk("timeout_len", n, TIMEOUT);
      chk("timeout_sel", select_item, 3'b111);
      // mode and next in the same cycle: mode wins
      pulse(0);
      tick(2);
      pulse(1);
      tick(2);
      chk("pre_mode_next_sel", select_item, 3'b001);
      btn[1:0] = 2'b11;
      tick(1);
      btn[1:0] = 2'b00;
      tick(2);
      chk("mode_wins", {en_1, select_item, up, down}, 6'b111100);
      // reset in the middle of a down hold
      pulse(0);
      tick(2);
      btn[3] = 1'b1;
      tick(6);
      #2 rst_n = 1'b0;
      #1 chk("reset_async", {en_1, select_item, up, down, blink}, 7'b1111000);
      @(negedge clk_1Hz);
      rst_n = 1'b1;
      tick(3);
      pulse(0);
      tick(2);
      chk("reentry_after_reset", en_1, 0);
      for (int i = 0; i < 8; i++) begin
         tick(1);
         chk("held_thru_reset", down, 0);
      end
      btn[3] = 1'b0;
      tick(3);
      btn[3] = 1'b1;
      tick(3);
      chk("repress_down", down, 1);
      btn[3] = 1'b0;
      tick(4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
